// File: rtl/f1_light_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : f1_light_ctrl
// Description : Start-lights sequencing controller for the reaction game.
//               The LFSR runs freely while the controller is idle. On
//               trigger, one LFSR sample is captured as the hold delay. The
//               lamps are then lit one per timebase tick, held for that many
//               ticks, and extinguished together with a one-cycle go pulse.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH   - width of the LFSR sample and of the hold delay counter
//   LIGHTS  - number of lamps (>= 2)
// Ports
//   clk     in   system clock
//   rst     in   asynchronous active-high reset
//   trigger in   round start request, level-sampled on the clock edge
//   tick    in   one-cycle timebase strobe from the prescaler
//   rnd     in   current LFSR value [WIDTH]
//   lfsr_en out  LIGHTS-free LFSR advance enable (high while idle)
//   lights  out  lamp drive [LIGHTS]; bit 0 is the first lamp lit
//   busy    out  high while a round is in progress
//   go      out  one-cycle pulse when the lamps extinguish
// Build options
//   F1_ABORT_EN - when defined, trigger during a round aborts it
// ============================================================================
module f1_light_ctrl #(
  parameter int WIDTH  = 7,
  parameter int LIGHTS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trigger,
  input  logic              tick,
  input  logic [WIDTH-1:0]  rnd,
  output logic              lfsr_en,
  output logic [LIGHTS-1:0] lights,
  output logic              busy,
  output logic              go
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [LIGHTS-1:0] c_all_on   = {LIGHTS{1'b1}};
  localparam logic [LIGHTS-1:0] c_first_on = {{(LIGHTS-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]  c_one      = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t            r_state;
  logic [LIGHTS-1:0] r_lights;
  logic              r_busy;
  logic              r_go;
  logic [WIDTH-1:0]  r_count;

  state_t            w_state_nxt;
  logic [LIGHTS-1:0] w_lights_nxt;
  logic              w_busy_nxt;
  logic              w_go_nxt;
  logic [WIDTH-1:0]  w_count_nxt;
  logic [LIGHTS-1:0] w_shifted;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_lights <= '0;
      r_busy   <= 1'b0;
      r_go     <= 1'b0;
      r_count  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_lights <= w_lights_nxt;
      r_busy   <= w_busy_nxt;
      r_go     <= w_go_nxt;
      r_count  <= w_count_nxt;
    end
  end

  assign w_shifted = {r_lights[LIGHTS-2:0], 1'b1};

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt  = r_state;
    w_lights_nxt = r_lights;
    w_busy_nxt   = r_busy;
    w_go_nxt     = 1'b0;
    w_count_nxt  = r_count;

    case (r_state)
      ST_IDLE: begin
        // A tick coinciding with the accepting trigger is deliberately not
        // counted: the first lamp is lit by the trigger itself.
        if (trigger) begin
          // A zero sample would make the hold phase last 2^WIDTH ticks
          // through wrap-around, so it is forced to the shortest delay.
          w_count_nxt  = (rnd == '0) ? c_one : rnd;
          w_lights_nxt = c_first_on;
          w_busy_nxt   = 1'b1;
          w_state_nxt  = ST_FILL;
        end
      end

      ST_FILL: begin
`ifdef F1_ABORT_EN
        if (trigger) begin
          w_lights_nxt = '0;
          w_busy_nxt   = 1'b0;
          w_state_nxt  = ST_IDLE;
        end else
`endif
        if (tick) begin
          w_lights_nxt = w_shifted;
          if (w_shifted == c_all_on) begin
            w_state_nxt = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
`ifdef F1_ABORT_EN
        if (trigger) begin
          w_lights_nxt = '0;
          w_busy_nxt   = 1'b0;
          w_state_nxt  = ST_IDLE;
        end else
`endif
        if (tick) begin
          if (r_count == c_one) begin
            w_lights_nxt = '0;
            w_go_nxt     = 1'b1;
            w_busy_nxt   = 1'b0;
            w_state_nxt  = ST_IDLE;
          end else begin
            w_count_nxt = r_count - c_one;
          end
        end
      end

      default: begin
        // Unused encoding: recover to idle with everything cleared.
        w_state_nxt  = ST_IDLE;
        w_lights_nxt = '0;
        w_busy_nxt   = 1'b0;
        w_go_nxt     = 1'b0;
        w_count_nxt  = '0;
      end
    endcase
  end

  assign lfsr_en = (r_state == ST_IDLE);
  assign lights  = r_lights;
  assign busy    = r_busy;
  assign go      = r_go;

endmodule
`default_nettype wire

// File: tb/tb_f1_light_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_f1_light_ctrl
// Description : Self-checking bench for f1_light_ctrl. A directed vector
//               table, hand-written corner sequences and a randomized run
//               are compared against a round-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_f1_light_ctrl;

  localparam int WIDTH  = 7;
  localparam int LIGHTS = 8;

  logic              clk;
  logic              rst;
  logic              trigger;
  logic              tick;
  logic [WIDTH-1:0]  rnd;
  logic              lfsr_en;
  logic [LIGHTS-1:0] lights;
  logic              busy;
  logic              go;

  int n_pass  = 0;
  int n_total = 0;

  f1_light_ctrl #(.WIDTH(WIDTH), .LIGHTS(LIGHTS)) dut (
    .clk     (clk),
    .rst     (rst),
    .trigger (trigger),
    .tick    (tick),
    .rnd     (rnd),
    .lfsr_en (lfsr_en),
    .lights  (lights),
    .busy    (busy),
    .go      (go)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a round is described by whether it is running, how
  // many ticks it has counted since the trigger, and its hold length.
  logic m_busy;
  logic m_go;
  int   m_ticks;
  int   m_hold;

  function automatic logic [LIGHTS-1:0] model_lights();
    logic [LIGHTS-1:0] v;
    v = '0;
    if (m_busy)
      for (int i = 0; i < LIGHTS; i++) v[i] = (i <= m_ticks);
    return v;
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_go    = 1'b0;
    m_ticks = 0;
    m_hold  = 0;
  endtask

  task automatic model_edge(input logic trg, input logic tk, input int r);
    m_go = 1'b0;
    if (!m_busy) begin
      if (trg) begin
        m_busy  = 1'b1;
        m_ticks = 0;
        m_hold  = (r == 0) ? 1 : r;
      end
    end else begin
`ifdef F1_ABORT_EN
      if (trg) begin
        m_busy = 1'b0;
      end else
`endif
      if (tk) begin
        m_ticks++;
        if (m_ticks == (LIGHTS - 1) + m_hold) begin
          m_busy = 1'b0;
          m_go   = 1'b1;
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".lights"},  32'(lights),  32'(model_lights()));
    check({tag, ".busy"},    32'(busy),    32'(m_busy));
    check({tag, ".go"},      32'(go),      32'(m_go));
    check({tag, ".lfsr_en"}, 32'(lfsr_en), 32'(!m_busy));
  endtask

  // Drive inputs on the falling edge, let one rising edge pass, and leave
  // the bench 1 time unit after that edge with the model updated.
  task automatic step(input logic trg, input logic tk, input logic [WIDTH-1:0] r);
    @(negedge clk);
    trigger = trg;
    tick    = tk;
    rnd     = r;
    @(posedge clk);
    model_edge(trg, tk, int'(r));
    #1;
  endtask

  typedef struct {
    logic              trg;
    logic              tk;
    logic [WIDTH-1:0]  r;
    logic [LIGHTS-1:0] e_lights;
    logic              e_busy;
    logic              e_go;
    logic              e_en;
  } vec_t;

  vec_t vecs[15];

  task automatic setv(input int i, input logic trg, input logic tk, input logic [WIDTH-1:0] r,
                      input logic [LIGHTS-1:0] el, input logic eb, input logic eg, input logic ee);
    vecs[i].trg = trg; vecs[i].tk = tk; vecs[i].r = r;
    vecs[i].e_lights = el; vecs[i].e_busy = eb; vecs[i].e_go = eg; vecs[i].e_en = ee;
  endtask

  initial begin
    rst = 1'b1; trigger = 1'b0; tick = 1'b0; rnd = '0;
    model_reset();

    // Normal round with rnd=5; the tick coincident with the trigger is ignored.
    setv(0,  1'b1, 1'b1, 7'd5,  8'h01, 1'b1, 1'b0, 1'b0);
    setv(1,  1'b0, 1'b1, 7'd9,  8'h03, 1'b1, 1'b0, 1'b0);
    setv(2,  1'b0, 1'b1, 7'd9,  8'h07, 1'b1, 1'b0, 1'b0);
    setv(3,  1'b0, 1'b0, 7'd9,  8'h07, 1'b1, 1'b0, 1'b0);
    setv(4,  1'b0, 1'b1, 7'd9,  8'h0F, 1'b1, 1'b0, 1'b0);
    setv(5,  1'b0, 1'b1, 7'd9,  8'h1F, 1'b1, 1'b0, 1'b0);
    setv(6,  1'b0, 1'b1, 7'd9,  8'h3F, 1'b1, 1'b0, 1'b0);
    setv(7,  1'b0, 1'b1, 7'd9,  8'h7F, 1'b1, 1'b0, 1'b0);
    setv(8,  1'b0, 1'b1, 7'd9,  8'hFF, 1'b1, 1'b0, 1'b0);
    setv(9,  1'b0, 1'b1, 7'd9,  8'hFF, 1'b1, 1'b0, 1'b0);
    setv(10, 1'b0, 1'b1, 7'd9,  8'hFF, 1'b1, 1'b0, 1'b0);
    setv(11, 1'b0, 1'b1, 7'd9,  8'hFF, 1'b1, 1'b0, 1'b0);
    setv(12, 1'b0, 1'b1, 7'd9,  8'hFF, 1'b1, 1'b0, 1'b0);
    setv(13, 1'b0, 1'b1, 7'd9,  8'h00, 1'b0, 1'b1, 1'b1);
    setv(14, 1'b0, 1'b0, 7'd9,  8'h00, 1'b0, 1'b0, 1'b1);

    // Reset state, held across a couple of edges
    #2;
    check("reset.lights",  32'(lights),  32'h0);
    check("reset.busy",    32'(busy),    32'h0);
    check("reset.go",      32'(go),      32'h0);
    check("reset.lfsr_en", 32'(lfsr_en), 32'h1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      step(vecs[i].trg, vecs[i].tk, vecs[i].r);
      check($sformatf("vec%0d.lights", i),  32'(lights),  32'(vecs[i].e_lights));
      check($sformatf("vec%0d.busy", i),    32'(busy),    32'(vecs[i].e_busy));
      check($sformatf("vec%0d.go", i),      32'(go),      32'(vecs[i].e_go));
      check($sformatf("vec%0d.lfsr_en", i), 32'(lfsr_en), 32'(vecs[i].e_en));
    end

    // rnd=0: hold lasts exactly one tick
    step(1'b1, 1'b0, 7'd0);
    repeat (LIGHTS - 1) step(1'b0, 1'b1, 7'd33);
    check("rnd0.full", 32'(lights), 32'hFF);
    check("rnd0.nogo", 32'(go), 32'h0);
    step(1'b0, 1'b1, 7'd33);
    check("rnd0.go", 32'(go), 32'h1);
    check("rnd0.off", 32'(lights), 32'h0);
    step(1'b0, 1'b0, 7'd33);
    check("rnd0.go_once", 32'(go), 32'h0);

    // rnd=127: hold lasts 127 ticks
    step(1'b1, 1'b0, 7'd127);
    repeat (LIGHTS - 1 + 126) step(1'b0, 1'b1, 7'd0);
    check("rnd127.pre", 32'({busy, go, lights}), 32'({1'b1, 1'b0, 8'hFF}));
    step(1'b0, 1'b1, 7'd0);
    check("rnd127.go", 32'({busy, go, lights}), 32'({1'b0, 1'b1, 8'h00}));

    // Trigger pulse during hold
    step(1'b1, 1'b0, 7'd3);
    repeat (LIGHTS - 1) step(1'b0, 1'b1, 7'd0);
    step(1'b1, 1'b0, 7'd0);
`ifdef F1_ABORT_EN
    check("hold_trig.lights", 32'(lights), 32'h00);
    check("hold_trig.busy",   32'(busy),   32'h0);
`else
    check("hold_trig.lights", 32'(lights), 32'hFF);
    check("hold_trig.busy",   32'(busy),   32'h1);
`endif
    repeat (3) begin
      step(1'b0, 1'b1, 7'd0);
      check_model("hold_trig");
    end
    check("hold_trig.nocarry", 32'(busy), 32'h0);

    // Asynchronous reset in the middle of a hold
    step(1'b1, 1'b0, 7'd50);
    repeat (LIGHTS + 1) step(1'b0, 1'b1, 7'd0);
    check("rst_mid.full", 32'(lights), 32'hFF);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid.lights",  32'(lights),  32'h0);
    check("rst_mid.busy",    32'(busy),    32'h0);
    check("rst_mid.go",      32'(go),      32'h0);
    check("rst_mid.lfsr_en", 32'(lfsr_en), 32'h1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0, 7'd2);
    check("rst_mid.restart", 32'(lights), 32'h01);
    check_model("rst_mid.restart");

    // Randomized run against the model
    for (int c = 0; c < 4000; c++) begin
      logic [WIDTH-1:0] r;
      r = ($urandom_range(0, 15) == 0) ? WIDTH'($urandom_range(0, 127)) : WIDTH'($urandom_range(0, 12));
      step(($urandom_range(0, 5) == 0), $urandom_range(0, 1) == 1, r);
      check_model("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/f1_light_ctrl.md
# f1_light_ctrl

Sequencing controller for the start-lights reaction game. It drives the enable of the free-running LFSR and captures one LFSR sample per round as a random hold delay. It then lights LIGHTS lamps one per timebase tick, holds them for the random number of ticks, and extinguishes them with a one-cycle `go` pulse. It sits between the LFSR, the millisecond/second tick prescaler and the lamp/display outputs.

## Interface
- `WIDTH`, 7: width of the LFSR sample and of the internal delay counter.
- `LIGHTS`, 8: number of lamps. Must be at least 2.

- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high. Clock is `clk`.
- `trigger`  in  1  round start request, level-sampled at `clk` rising edge.
- `tick`  in  1  one-cycle timebase strobe from the prescaler.
- `rnd`  in  WIDTH  current LFSR value.
- `lfsr_en`  out  1  LFSR advance enable.
- `lights`  out  LIGHTS  lamp drive; bit 0 is the first lamp lit.
- `busy`  out  1  high while a round is in progress.
- `go`  out  1  one-cycle pulse when the lamps extinguish.

## Operation
- States: IDLE, FILL, HOLD. Reset enters IDLE.
- Reset values: `lights`=0, `busy`=0, `go`=0, delay counter=0, state IDLE.
- `lfsr_en` = (state==IDLE), combinational, so it is 1 during and after reset. The LFSR free-runs between rounds and is frozen during a round.
- IDLE, `trigger`=1:
  - delay counter <= (`rnd`==0 ? 1 : `rnd`).
  - `lights` <= 1.
  - `busy` <= 1.
  - next state FILL.
  - A `tick` in the same cycle is ignored.
- FILL, `tick`=1: `lights` <= {`lights`[LIGHTS-2:0],1'b1}. If the new value is all ones, next state HOLD.
- HOLD, `tick`=1:
  - If counter==1: `lights` <= 0, `go` <= 1, `busy` <= 0, next state IDLE.
  - Otherwise: counter <= counter-1.
- `go` is registered and high for exactly one cycle. In all other cycles it is 0.
- `trigger` in FILL or HOLD is ignored (default build). A held `trigger` restarts a new round on the first cycle back in IDLE.
- Counter arithmetic is unsigned WIDTH-bit. Counter values range from 1 to 2^WIDTH-1, so the counter never wraps.
- Any state encoding not listed returns to IDLE on the next edge with all outputs at their reset values.

## Timing
- Trigger accepted at edge T: `lights`=...001 and `busy`=1 after T. `lfsr_en` drops in the cycle after T.
- `lights` becomes all ones on the (LIGHTS-1)th tick after T; that same edge enters HOLD.
- `go`=1 and `lights`=0 after the Dth HOLD tick, where D=max(`rnd` at T, 1).
- The edge that ends HOLD also enters IDLE, so `lfsr_en`=1 in the same cycle as the `go` pulse. `trigger` is accepted from that cycle onward.
- `rst` mid-round clears all outputs immediately, without waiting for a clock edge. No `go` is produced.
- `tick` and `trigger` present together in FILL or HOLD: the tick is processed and the trigger is ignored (default build).

## Configuration
- Macro `F1_ABORT_EN`.
- Defined: `trigger`=1 in FILL or HOLD aborts the round.
  - Next edge: `lights`=0, `busy`=0, state IDLE, no `go`.
  - Abort has priority over a coincident `tick`.
  - The abort cycle does not start a new round; `trigger` must still be high in IDLE to start one.
- Undefined: `trigger` is ignored outside IDLE, as described in Operation.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → `lights`=0x00, `busy`=0, `go`=0, `lfsr_en`=1 immediately.
- Normal round, WIDTH=7, LIGHTS=8, `rnd`=5 at trigger:
  - `lights` steps 0x01, 0x03, …, 0xFF over 7 ticks.
  - After 5 more ticks: `go` is a one-cycle pulse, `lights`=0x00, `busy`=0.
  - `lfsr_en`=0 throughout FILL and HOLD.
- `rnd`=0 at trigger → HOLD lasts exactly 1 tick. `rnd`=127 → HOLD lasts 127 ticks.
- `tick` coincident with the accepting `trigger` → not counted; 0xFF is still reached after 7 further ticks.
- `trigger` pulse in HOLD:
  - Default build: ignored, and `go` arrives on schedule.
  - `F1_ABORT_EN` build: `lights`=0x00 next cycle and no `go`.
- `rst` pulse during HOLD with `lights`=0xFF → outputs clear immediately. After release, a new `trigger` starts a clean round at 0x01.
